// File: rtl/powerup_spawner.sv
// Queues destroyed-block events and turns spaced-out random draws into power-up spawn offers.
// Optional SPAWN_STATS_EN adds spawn_total/draw_total counters.
module powerup_spawner #(
   parameter int CELL_W     = 7,
   parameter int FIFO_DEPTH = 4,
   parameter int RND_GAP    = 14,
   localparam int PTR_W     = $clog2(FIFO_DEPTH),
   localparam int CNT_W     = PTR_W + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              destroy_valid,
   output logic              destroy_ready,
   input  logic [CELL_W-1:0] destroy_cell,
   input  logic [3:0]        rnd,
   output logic              spawn_valid,
   input  logic              spawn_ready,
   output logic [CELL_W-1:0] spawn_cell,
   output logic [1:0]        spawn_type,
   output logic [CNT_W-1:0]  fifo_count
`ifdef SPAWN_STATS_EN
   ,
   output logic [7:0]        spawn_total,
   output logic [7:0]        draw_total
`endif
);

   localparam int GAP_W = $clog2(RND_GAP + 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(RND_GAP - 1);

   typedef enum logic {IDLE, OFFER} state_t;

   logic [CELL_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   state_t            state_q, state_d;
   logic [CELL_W-1:0] cell_q, cell_d;
   logic [1:0]        type_q, type_d;
   logic              push, draw;
   logic [1:0]        drop_type;

   assign destroy_ready = (count_q != CNT_W'(FIFO_DEPTH));
   assign push          = destroy_valid && destroy_ready;
   assign draw          = (state_q == IDLE) && (count_q != '0) && (gap_q == '0);
   assign spawn_valid   = (state_q == OFFER);
   assign spawn_cell    = cell_q;
   assign spawn_type    = type_q;
   assign fifo_count    = count_q;

   // Only one-hot generator codes map to a drop; everything else yields nothing.
   always_comb begin
      drop_type = 2'd0;
      case (rnd)
         4'd2:    drop_type = 2'd1;
         4'd4:    drop_type = 2'd2;
         4'd8:    drop_type = 2'd3;
         default: drop_type = 2'd0;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      gap_d    = gap_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (draw) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !draw)      count_d = count_q + CNT_W'(1);
      else if (!push && draw) count_d = count_q - CNT_W'(1);
      if (draw)               gap_d = GAP_LOAD;
      else if (gap_q != '0)   gap_d = gap_q - GAP_W'(1);
   end

   always_comb begin
      state_d = state_q;
      cell_d  = cell_q;
      type_d  = type_q;
      case (state_q)
         IDLE: begin
            if (draw && (drop_type != 2'd0)) begin
               state_d = OFFER;
               cell_d  = mem_q[rd_ptr_q];
               type_d  = drop_type;
            end
         end
         OFFER: begin
            if (spawn_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= destroy_cell;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         gap_q    <= '0;
         state_q  <= IDLE;
         cell_q   <= '0;
         type_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         gap_q    <= gap_d;
         state_q  <= state_d;
         cell_q   <= cell_d;
         type_q   <= type_d;
      end
   end

`ifdef SPAWN_STATS_EN
   logic [7:0] spawn_total_q, draw_total_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         spawn_total_q <= '0;
         draw_total_q  <= '0;
      end else begin
         if (spawn_valid && spawn_ready) spawn_total_q <= spawn_total_q + 8'd1;
         if (draw)                       draw_total_q  <= draw_total_q + 8'd1;
      end
   end

   assign spawn_total = spawn_total_q;
   assign draw_total  = draw_total_q;
`endif

endmodule

// File: tb/tb_powerup_spawner.sv
// Directed self-checking bench for powerup_spawner (default parameters).
module tb_powerup_spawner;

   logic       clock;
   logic       reset;
   logic       destroy_valid;
   logic       destroy_ready;
   logic [6:0] destroy_cell;
   logic [3:0] rnd;
   logic       spawn_valid;
   logic       spawn_ready;
   logic [6:0] spawn_cell;
   logic [1:0] spawn_type;
   logic [2:0] fifo_count;
`ifdef SPAWN_STATS_EN
   logic [7:0] spawn_total;
   logic [7:0] draw_total;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   powerup_spawner #(.CELL_W(7), .FIFO_DEPTH(4), .RND_GAP(14)) dut (
      .clock         (clock),
      .reset         (reset),
      .destroy_valid (destroy_valid),
      .destroy_ready (destroy_ready),
      .destroy_cell  (destroy_cell),
      .rnd           (rnd),
      .spawn_valid   (spawn_valid),
      .spawn_ready   (spawn_ready),
      .spawn_cell    (spawn_cell),
      .spawn_type    (spawn_type),
      .fifo_count    (fifo_count)
`ifdef SPAWN_STATS_EN
      ,
      .spawn_total   (spawn_total),
      .draw_total    (draw_total)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; destroy_valid = 1'b0; destroy_cell = '0; rnd = '0; spawn_ready = 1'b0;
      idle(3);
      n_checks++; if (destroy_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", destroy_ready); end
      n_checks++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", spawn_valid); end
      n_checks++; if (spawn_cell !== 7'h00) begin n_fail++; $display("FAIL reset_cell: got %h expected 00", spawn_cell); end
      n_checks++; if (spawn_type !== 2'd0) begin n_fail++; $display("FAIL reset_type: got %0d expected 0", spawn_type); end
      n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      destroy_valid = 1'b1; destroy_cell = 7'h23; rnd = 4'd2; spawn_ready = 1'b1;
      tick();
      destroy_valid = 1'b0;
      n_checks++; if (spawn_valid !== 1'b0 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_after_push: valid=%b count=%0d expected valid=0 count=1", spawn_valid, fifo_count); end
      tick();
      n_checks++; if (spawn_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", spawn_valid); end
      n_checks++; if (spawn_cell !== 7'h23 || spawn_type !== 2'd1) begin n_fail++; $display("FAIL single_payload: cell=%h type=%0d expected cell=23 type=1", spawn_cell, spawn_type); end
      n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_count: got %0d expected 0", fifo_count); end
      $display("spawn cell=%h type=%0d", spawn_cell, spawn_type);
      tick();
      n_checks++; if (spawn_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b expected 0", spawn_valid); end
      idle(20);
   endtask

   task automatic test_sequence();
      logic [6:0] cells [3];
      logic [3:0] rseq [3];
      int         draw_c [3];
      logic [6:0] sc [2];
      logic [1:0] st [2];
      int         np, nd, ns, prev, popped;
      logic       pv;
      cells[0] = 7'h11; cells[1] = 7'h22; cells[2] = 7'h33;
      rseq[0] = 4'd4; rseq[1] = 4'd5; rseq[2] = 4'd8;
      for (int i = 0; i < 3; i++) draw_c[i] = -100;
      sc[0] = '0; sc[1] = '0; st[0] = '0; st[1] = '0;
      np = 0; nd = 0; ns = 0; prev = int'(fifo_count);
      rnd = rseq[0]; spawn_ready = 1'b1; destroy_valid = 1'b1; destroy_cell = cells[0];
      for (int c = 0; c < 40; c++) begin
         pv = destroy_valid && destroy_ready;
         tick();
         if (pv) begin
            np++;
            if (np < 3) destroy_cell = cells[np];
            else destroy_valid = 1'b0;
         end
         popped = prev + int'(pv) - int'(fifo_count);
         if (popped == 1) begin
            if (nd < 3) draw_c[nd] = c;
            nd++;
            if (nd < 3) rnd = rseq[nd];
         end
         if (spawn_valid === 1'b1) begin
            if (ns < 2) begin sc[ns] = spawn_cell; st[ns] = spawn_type; end
            ns++;
            $display("spawn cell=%h type=%0d", spawn_cell, spawn_type);
         end
         prev = int'(fifo_count);
      end
      n_checks++; if (nd !== 3) begin n_fail++; $display("FAIL seq_draws: got %0d expected 3", nd); end
      n_checks++; if (draw_c[0] !== 1) begin n_fail++; $display("FAIL seq_first_draw: got cycle %0d expected 1", draw_c[0]); end
      n_checks++; if (draw_c[1] - draw_c[0] !== 14) begin n_fail++; $display("FAIL seq_gap1: got %0d expected 14", draw_c[1] - draw_c[0]); end
      n_checks++; if (draw_c[2] - draw_c[1] !== 14) begin n_fail++; $display("FAIL seq_gap2: got %0d expected 14", draw_c[2] - draw_c[1]); end
      n_checks++; if (ns !== 2) begin n_fail++; $display("FAIL seq_spawns: got %0d expected 2", ns); end
      n_checks++; if (sc[0] !== 7'h11 || st[0] !== 2'd2) begin n_fail++; $display("FAIL seq_spawn0: cell=%h type=%0d expected cell=11 type=2", sc[0], st[0]); end
      n_checks++; if (sc[1] !== 7'h33 || st[1] !== 2'd3) begin n_fail++; $display("FAIL seq_spawn1: cell=%h type=%0d expected cell=33 type=3", sc[1], st[1]); end
      n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL seq_count: got %0d expected 0", fifo_count); end
      idle(20);
   endtask

   task automatic test_full();
      int bad;
      destroy_valid = 1'b1; destroy_cell = 7'h40; rnd = 4'd2; spawn_ready = 1'b0;
      tick();
      destroy_valid = 1'b0;
      tick();
      n_checks++; if (spawn_valid !== 1'b1 || spawn_cell !== 7'h40) begin n_fail++; $display("FAIL full_offer: valid=%b cell=%h expected valid=1 cell=40", spawn_valid, spawn_cell); end
      destroy_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         destroy_cell = 7'h41 + 7'(i);
         tick();
      end
      destroy_cell = 7'h45;
      n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_peak: got %0d expected 4", fifo_count); end
      n_checks++; if (destroy_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %b expected 0", destroy_ready); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (spawn_valid !== 1'b1 || spawn_cell !== 7'h40 || spawn_type !== 2'd1 || fifo_count !== 3'd4 || destroy_ready !== 1'b0) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_stall_stable: %0d unstable cycles expected 0", bad); end
      spawn_ready = 1'b1;
      tick();
      n_checks++; if (spawn_valid !== 1'b0 || fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_handshake: valid=%b count=%0d expected valid=0 count=4", spawn_valid, fifo_count); end
      tick();
      n_checks++; if (spawn_valid !== 1'b1 || spawn_cell !== 7'h41 || fifo_count !== 3'd3 || destroy_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop: valid=%b cell=%h count=%0d ready=%b expected 1 41 3 1", spawn_valid, spawn_cell, fifo_count, destroy_ready); end
      tick();
      destroy_valid = 1'b0;
      n_checks++; if (fifo_count !== 3'd4 || spawn_valid !== 1'b0) begin n_fail++; $display("FAIL full_held_accept: count=%0d valid=%b expected count=4 valid=0", fifo_count, spawn_valid); end
   endtask

   task automatic test_nodrop();
      logic [3:0] rseq [4];
      int         draw_c [4];
      int         nd, prev, spawns;
      rseq[0] = 4'hF; rseq[1] = 4'h0; rseq[2] = 4'hF; rseq[3] = 4'h0;
      for (int i = 0; i < 4; i++) draw_c[i] = -100;
      nd = 0; spawns = 0; prev = int'(fifo_count);
      rnd = rseq[0]; spawn_ready = 1'b1;
      for (int c = 0; c < 64; c++) begin
         tick();
         if (prev - int'(fifo_count) == 1) begin
            if (nd < 4) draw_c[nd] = c;
            nd++;
            if (nd < 4) rnd = rseq[nd];
         end
         if (spawn_valid !== 1'b0) spawns++;
         prev = int'(fifo_count);
      end
      n_checks++; if (nd !== 4) begin n_fail++; $display("FAIL nodrop_draws: got %0d expected 4", nd); end
      n_checks++; if (draw_c[0] !== 12) begin n_fail++; $display("FAIL nodrop_first_draw: got cycle %0d expected 12", draw_c[0]); end
      n_checks++; if (draw_c[1] - draw_c[0] !== 14 || draw_c[2] - draw_c[1] !== 14 || draw_c[3] - draw_c[2] !== 14) begin n_fail++; $display("FAIL nodrop_gap: cycles %0d %0d %0d %0d expected 14 apart", draw_c[0], draw_c[1], draw_c[2], draw_c[3]); end
      n_checks++; if (spawns !== 0) begin n_fail++; $display("FAIL nodrop_spawn: got %0d valid cycles expected 0", spawns); end
      n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL nodrop_count: got %0d expected 0", fifo_count); end
      idle(20);
   endtask

   task automatic test_reset_mid();
      int bad;
      destroy_valid = 1'b1; destroy_cell = 7'h51; rnd = 4'd8; spawn_ready = 1'b0;
      tick();
      destroy_cell = 7'h52;
      tick();
      destroy_cell = 7'h53;
      tick();
      destroy_valid = 1'b0;
      n_checks++; if (spawn_valid !== 1'b1 || spawn_cell !== 7'h51 || spawn_type !== 2'd3 || fifo_count !== 3'd2) begin n_fail++; $display("FAIL rmid_setup: valid=%b cell=%h type=%0d count=%0d expected 1 51 3 2", spawn_valid, spawn_cell, spawn_type, fifo_count); end
`ifdef SPAWN_STATS_EN
      n_checks++; if (draw_total !== 8'd11 || spawn_total !== 8'd5) begin n_fail++; $display("FAIL stats_totals: draws=%0d spawns=%0d expected 11 5", draw_total, spawn_total); end
`endif
      reset = 1'b1; destroy_valid = 1'b1; destroy_cell = 7'h54; spawn_ready = 1'b1;
      tick();
      n_checks++; if (spawn_valid !== 1'b0 || fifo_count !== 3'd0 || destroy_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_reset: valid=%b count=%0d ready=%b expected 0 0 1", spawn_valid, fifo_count, destroy_ready); end
      n_checks++; if (spawn_cell !== 7'h00 || spawn_type !== 2'd0) begin n_fail++; $display("FAIL rmid_payload: cell=%h type=%0d expected 00 0", spawn_cell, spawn_type); end
`ifdef SPAWN_STATS_EN
      n_checks++; if (draw_total !== 8'd0 || spawn_total !== 8'd0) begin n_fail++; $display("FAIL stats_reset: draws=%0d spawns=%0d expected 0 0", draw_total, spawn_total); end
`endif
      reset = 1'b0; destroy_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (spawn_valid !== 1'b0 || fifo_count !== 3'd0) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_quiet: %0d active cycles expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_sequence();
      test_full();
      test_nodrop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
